// File: rtl/nl_seq_pkg.sv
// Shared definitions for the non-linear sequence scheduler: FSM states, command
// op codes and the 0->1->3->6->2->5->4->0 successor function.
package nl_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [1:0] OP_NOP      = 2'b00;
  localparam logic [1:0] OP_RUN_N    = 2'b01;
  localparam logic [1:0] OP_RUN_CONT = 2'b10;
  localparam logic [1:0] OP_STOP     = 2'b11;

  function automatic logic [2:0] nl_seq_next(input logic [2:0] cur);
    logic [2:0] nxt;
    case (cur)
      3'd0:    nxt = 3'd1;
      3'd1:    nxt = 3'd3;
      3'd3:    nxt = 3'd6;
      3'd6:    nxt = 3'd2;
      3'd2:    nxt = 3'd5;
      3'd5:    nxt = 3'd4;
      default: nxt = 3'd0;  // 4, and the unreachable 7, both return to 0
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/nl_seq_gen.sv
// Enabled 3-bit sequence register; clr beats en, wrap pulses with the 4->0 step.
module nl_seq_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] seq_val,
  output logic       wrap
);
  import nl_seq_pkg::*;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_val <= 3'd0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        seq_val <= 3'd0;
      end else if (en) begin
        seq_val <= nl_seq_next(seq_val);
        wrap    <= (seq_val == 3'd4);
      end
    end
  end

endmodule

// File: rtl/nl_seq_scheduler.sv
// Run controller for the non-linear sequence: command handshake, FSM, prescaler,
// step counter. Define NL_SEQ_SYNC_CLEAR_EN to add the synchronous seq_clr input.
module nl_seq_scheduler #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [CNT_W-1:0]      cmd_steps,
  input  logic [PRESCALE_W-1:0] cmd_div,
`ifdef NL_SEQ_SYNC_CLEAR_EN
  input  logic                  seq_clr,
`endif
  output logic [2:0]            seq_val,
  output logic                  step_pulse,
  output logic                  seq_wrap,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err,
  output logic [CNT_W-1:0]      steps_done
);
  import nl_seq_pkg::*;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [CNT_W-1:0]      target_q, target_d;
  logic                  cont_q, cont_d;
  logic [CNT_W-1:0]      steps_q, steps_d;
  logic                  err_d;
  logic                  clr, accept, is_run, is_stop, reached, advance;

`ifdef NL_SEQ_SYNC_CLEAR_EN
  assign clr = seq_clr;
`else
  assign clr = 1'b0;
`endif

  assign cmd_ready  = (state_q != DONE);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign steps_done = steps_q;

  assign accept  = cmd_valid && cmd_ready;
  assign is_run  = accept && ((cmd_op == OP_RUN_N) || (cmd_op == OP_RUN_CONT));
  assign is_stop = accept && (cmd_op == OP_STOP);
  // Target check uses the registered count, so DONE follows the final step by one edge.
  assign reached = !cont_q && (steps_q == target_q);
  assign advance = (state_q == RUN) && !is_stop && !reached && (presc_q == '0) && !clr;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    div_d    = div_q;
    target_d = target_q;
    cont_d   = cont_q;
    steps_d  = steps_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_run) begin
          steps_d  = '0;
          presc_d  = cmd_div;
          div_d    = cmd_div;
          target_d = cmd_steps;
          cont_d   = (cmd_op == OP_RUN_CONT);
          if ((cmd_op == OP_RUN_N) && (cmd_steps == '0)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (is_stop) begin
          state_d = DONE;
        end else begin
          err_d = is_run;
          if (reached) begin
            state_d = DONE;
          end else if (advance) begin
            steps_d = steps_q + 1'b1;
            presc_d = div_q;
          end else if (!clr && (presc_q != '0)) begin
            presc_d = presc_q - 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      steps_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      div_q      <= '0;
      target_q   <= '0;
      cont_q     <= 1'b0;
      steps_q    <= '0;
      step_pulse <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      div_q      <= div_d;
      target_q   <= target_d;
      cont_q     <= cont_d;
      steps_q    <= steps_d;
      step_pulse <= advance;
      cmd_err    <= err_d;
    end
  end

  nl_seq_gen u_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (advance),
    .clr     (clr),
    .seq_val (seq_val),
    .wrap    (seq_wrap)
  );

endmodule

// File: tb/tb_nl_seq_scheduler.sv
// Scoreboard bench for nl_seq_scheduler: directed commands push expected step/err/done
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_nl_seq_scheduler;

  localparam logic [1:0] NOP = 2'b00, RUN_N = 2'b01, RUN_CONT = 2'b10, STOP = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = NOP;
  logic [7:0] cmd_steps = '0;
  logic [3:0] cmd_div = '0;
`ifdef NL_SEQ_SYNC_CLEAR_EN
  logic       seq_clr = 1'b0;
`endif
  logic [2:0] seq_val;
  logic       step_pulse, seq_wrap, busy, done, cmd_err;
  logic [7:0] steps_done;

  nl_seq_scheduler u_dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_steps  (cmd_steps),
    .cmd_div    (cmd_div),
`ifdef NL_SEQ_SYNC_CLEAR_EN
    .seq_clr    (seq_clr),
`endif
    .seq_val    (seq_val),
    .step_pulse (step_pulse),
    .seq_wrap   (seq_wrap),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err),
    .steps_done (steps_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] val;
    logic       wrap;
    logic [7:0] steps;
    bit         chk_steps;
  } ev_t;

  ev_t q_step[$];
  ev_t q_err[$];
  ev_t q_done[$];
  ev_t e;
  int  n_cmp  = 0;
  int  n_fail = 0;

  function automatic ev_t mk(int c, logic [2:0] v, logic w, logic [7:0] s, bit chk);
    ev_t r;
    r.cyc = c; r.val = v; r.wrap = w; r.steps = s; r.chk_steps = chk;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the oldest expectation of its kind.
  always @(negedge clk) begin
    if (!reset) begin
      if (step_pulse) begin
        n_cmp++;
        if (q_step.size() == 0) begin
          n_fail++;
          $display("FAIL step_unexpected: got step seq=%0d at cyc %0d expected none", seq_val, cyc);
        end else begin
          e = q_step.pop_front();
          if (cyc != e.cyc || seq_val != e.val || seq_wrap != e.wrap || steps_done != e.steps
              || !busy) begin
            n_fail++;
            $display("FAIL step: got cyc=%0d seq=%0d wrap=%0b steps=%0d busy=%0b expected cyc=%0d seq=%0d wrap=%0b steps=%0d busy=1",
                     cyc, seq_val, seq_wrap, steps_done, busy, e.cyc, e.val, e.wrap, e.steps);
          end
        end
      end else if (seq_wrap) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wrap_alone: got seq_wrap=1 expected 0 without step_pulse (cyc %0d)", cyc);
      end
      if (cmd_err) begin
        n_cmp++;
        if (q_err.size() == 0) begin
          n_fail++;
          $display("FAIL err_unexpected: got cmd_err at cyc %0d expected none", cyc);
        end else begin
          e = q_err.pop_front();
          if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL err: got cyc=%0d expected cyc=%0d", cyc, e.cyc);
          end
        end
      end
      if (done) begin
        n_cmp++;
        if (q_done.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: got done at cyc %0d expected none", cyc);
        end else begin
          e = q_done.pop_front();
          if (cyc != e.cyc || seq_val != e.val || (e.chk_steps && steps_done != e.steps)
              || busy || cmd_ready) begin
            n_fail++;
            $display("FAIL done: got cyc=%0d seq=%0d steps=%0d busy=%0b ready=%0b expected cyc=%0d seq=%0d steps=%0d busy=0 ready=0",
                     cyc, seq_val, steps_done, busy, cmd_ready, e.cyc, e.val, e.steps);
          end
        end
      end
    end
  end

  // Returns at the negedge that samples the state after edge t (always waits >= 1 negedge).
  task automatic to_sample(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // Called at a negedge; returns #1 after the accepting edge with its cycle number.
  task automatic issue(input logic [1:0] op, input logic [7:0] st, input logic [3:0] dv,
                       output int k);
    cmd_valid = 1'b1; cmd_op = op; cmd_steps = st; cmd_div = dv;
    check("cmd_ready_before_issue", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    k = cyc;
    cmd_valid = 1'b0; cmd_op = NOP;
  endtask

  task automatic settle(input int t, input string name);
    to_sample(t);
    check({name, "_idle_busy"}, int'(busy), 0);
    check({name, "_idle_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    int k, k2;
    logic [2:0] exp_seq [7];
    exp_seq[0] = 3'd1; exp_seq[1] = 3'd3; exp_seq[2] = 3'd6; exp_seq[3] = 3'd2;
    exp_seq[4] = 3'd5; exp_seq[5] = 3'd4; exp_seq[6] = 3'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_seq_val", int'(seq_val), 0);
    check("rst_steps_done", int'(steps_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cmd_ready), 1);
    reset = 1'b0;
    @(negedge clk);

    // RUN_N 7 steps, div 0, full lap from 0
    issue(RUN_N, 8'd7, 4'd0, k);
    for (int i = 0; i < 7; i++)
      q_step.push_back(mk(k + 1 + i, exp_seq[i], (i == 6), 8'(i + 1), 1'b1));
    q_done.push_back(mk(k + 8, 3'd0, 1'b0, 8'd7, 1'b1));
    to_sample(k + 3);
    check("runn_busy", int'(busy), 1);
    settle(k + 9, "runn");

    // RUN_N 0 steps: immediate done, no step
    issue(RUN_N, 8'd0, 4'd5, k);
    q_done.push_back(mk(k, 3'd0, 1'b0, 8'd0, 1'b0));
    settle(k + 2, "runn0");
    check("runn0_seq_val", int'(seq_val), 0);

    // RUN_CONT div 2, STOP on a prescale==0 edge
    issue(RUN_CONT, 8'd0, 4'd2, k);
    q_step.push_back(mk(k + 3, 3'd1, 1'b0, 8'd1, 1'b1));
    q_step.push_back(mk(k + 6, 3'd3, 1'b0, 8'd2, 1'b1));
    q_step.push_back(mk(k + 9, 3'd6, 1'b0, 8'd3, 1'b1));
    to_sample(k + 11);
    issue(STOP, 8'd0, 4'd0, k2);
    q_done.push_back(mk(k + 12, 3'd6, 1'b0, 8'd3, 1'b1));
    settle(k + 13, "stop");
    check("stop_seq_held", int'(seq_val), 6);

    // RUN_N 3 div 1 from 6, with a RUN_N arriving mid-run
    issue(RUN_N, 8'd3, 4'd1, k);
    q_step.push_back(mk(k + 2, 3'd2, 1'b0, 8'd1, 1'b1));
    q_step.push_back(mk(k + 4, 3'd5, 1'b0, 8'd2, 1'b1));
    q_step.push_back(mk(k + 6, 3'd4, 1'b0, 8'd3, 1'b1));
    q_done.push_back(mk(k + 7, 3'd4, 1'b0, 8'd3, 1'b1));
    to_sample(k + 2);
    issue(RUN_N, 8'd9, 4'd0, k2);
    q_err.push_back(mk(k + 3, 3'd0, 1'b0, 8'd0, 1'b0));
    settle(k + 8, "err");

    // Reset mid-run once seq_val reaches 6
    issue(RUN_CONT, 8'd0, 4'd0, k);
    q_step.push_back(mk(k + 1, 3'd0, 1'b1, 8'd1, 1'b1));
    q_step.push_back(mk(k + 2, 3'd1, 1'b0, 8'd2, 1'b1));
    q_step.push_back(mk(k + 3, 3'd3, 1'b0, 8'd3, 1'b1));
    q_step.push_back(mk(k + 4, 3'd6, 1'b0, 8'd4, 1'b1));
    to_sample(k + 4);
    #2 reset = 1'b1;
    #1;
    check("midrst_seq_val", int'(seq_val), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_done", int'(done), 0);
    check("midrst_steps", int'(steps_done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_done", int'(done), 0);
    check("postrst_busy", int'(busy), 0);

    // Illegal value 7 advances to 0
    force u_dut.u_gen.seq_val = 3'd7;
    #1;
    check("forced_seq_val", int'(seq_val), 7);
    @(negedge clk);
    issue(RUN_N, 8'd1, 4'd2, k);
    q_step.push_back(mk(k + 3, 3'd0, 1'b0, 8'd1, 1'b1));
    q_done.push_back(mk(k + 4, 3'd0, 1'b0, 8'd1, 1'b1));
    to_sample(k + 2);
    release u_dut.u_gen.seq_val;
    settle(k + 5, "ill7");

`ifdef NL_SEQ_SYNC_CLEAR_EN
    // Synchronous clear mid-run
    issue(RUN_CONT, 8'd0, 4'd0, k);
    q_step.push_back(mk(k + 1, 3'd1, 1'b0, 8'd1, 1'b1));
    q_step.push_back(mk(k + 2, 3'd3, 1'b0, 8'd2, 1'b1));
    to_sample(k + 2);
    seq_clr = 1'b1;
    @(posedge clk);
    #1 seq_clr = 1'b0;
    to_sample(k + 3);
    check("clr_seq_val", int'(seq_val), 0);
    check("clr_steps", int'(steps_done), 0);
    check("clr_busy", int'(busy), 1);
    q_step.push_back(mk(k + 4, 3'd1, 1'b0, 8'd1, 1'b1));
    to_sample(k + 4);
    issue(STOP, 8'd0, 4'd0, k2);
    q_done.push_back(mk(k + 5, 3'd1, 1'b0, 8'd1, 1'b1));
    settle(k + 6, "clr");
`endif

    repeat (2) @(negedge clk);
    check("queues_drained", q_step.size() + q_err.size() + q_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout at cyc %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
